// File: rtl/sw_cmd_conditioner_pkg.sv
// rtl/sw_cmd_conditioner_pkg.sv - shared constants for the switch conditioner and the downstream FSM
//
// Holds the CMD encodings, the default timing parameters and small helpers,
// so the downstream up/down FSM decodes exactly the same constants.
package sw_cmd_conditioner_pkg;

  localparam logic [1:0] CMD_HOLD  = 2'b00;
  localparam logic [1:0] CMD_UP    = 2'b01;
  localparam logic [1:0] CMD_DOWN  = 2'b10;
  localparam logic [1:0] CMD_FAULT = 2'b11;

  // 20 ms debounce and 1 Hz step at 50 MHz
  localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;
  localparam int DEFAULT_TICK_DIV        = 50000000;

  // Counter width for a terminal count of n-1, never narrower than 1 bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Switch levels {forward, backward} to step command.
  function automatic logic [1:0] encode_cmd(input logic [1:0] w);
    logic [1:0] cmd;
    cmd = CMD_HOLD;
    case (w)
      2'b00:   cmd = CMD_HOLD;
      2'b10:   cmd = CMD_UP;
      2'b01:   cmd = CMD_DOWN;
      default: cmd = CMD_FAULT;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/sw_cmd_conditioner_debounce_bit.sv
// rtl/sw_cmd_conditioner_debounce_bit.sv - one-bit 2-flop synchroniser plus debounce counter
//
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset
//   din    in   raw asynchronous switch level
//   level  out  debounced level (registered)
//   flip   out  combinational strobe: level changes on the coming edge
module debounce_bit
  import sw_cmd_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic flip
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;
  logic          differs;

  assign differs = (sync2 != level);
  // The sample has disagreed for DEBOUNCE_CYCLES consecutive edges including this one.
  assign flip    = differs && (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      if (!differs) begin
        cnt <= '0;
      end else if (flip) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/sw_cmd_conditioner.sv
// rtl/sw_cmd_conditioner.sv - switch synchronise/debounce, step tick and step command encode
//
// Ports:
//   CLOCK50  in   system clock (50 MHz)
//   KEY0     in   asynchronous active-low reset
//   SW_IN    in   raw switches, [1]=forward, [0]=backward
//   W        out  debounced switch levels, same order as SW_IN
//   W_CHG    out  one-cycle pulse in the cycle W takes a new value
//   TICK     out  one-cycle step enable every TICK_DIV cycles
//   CMD      out  step command captured at TICK (HOLD/UP/DOWN/FAULT)
module sw_cmd_conditioner
  import sw_cmd_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int TICK_DIV        = DEFAULT_TICK_DIV
) (
  input  logic       CLOCK50,
  input  logic       KEY0,
  input  logic [1:0] SW_IN,
  output logic [1:0] W,
  output logic       W_CHG,
  output logic       TICK,
  output logic [1:0] CMD
);

  localparam int TW = cnt_width(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  logic [1:0]    flip;
  logic [TW-1:0] tick_cnt;
  logic          tick_term;

  for (genvar i = 0; i < 2; i++) begin : g_db
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk  (CLOCK50),
      .rst_n(KEY0),
      .din  (SW_IN[i]),
      .level(W[i]),
      .flip (flip[i])
    );
  end

  assign tick_term = (tick_cnt == TICK_LAST);

  // CMD samples W as it stands before this edge, so a W update landing on
  // the tick edge is only seen at the following tick.
  always_ff @(posedge CLOCK50 or negedge KEY0) begin
    if (!KEY0) begin
      tick_cnt <= '0;
      TICK     <= 1'b0;
      CMD      <= CMD_HOLD;
      W_CHG    <= 1'b0;
    end else begin
      tick_cnt <= tick_term ? '0 : tick_cnt + TW'(1);
      TICK     <= tick_term;
      if (tick_term) begin
        CMD <= encode_cmd(W);
      end
      W_CHG <= |flip;
    end
  end

endmodule

// File: tb/tb_sw_cmd_conditioner.sv
// tb/tb_sw_cmd_conditioner.sv - randomized and directed bench against a window-based reference model
module tb_sw_cmd_conditioner;

  localparam int DC = 4;
  localparam int TD = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] sw = 2'b00;
  logic [1:0] w;
  logic       w_chg;
  logic       tick;
  logic [1:0] cmd;

  int checks = 0;
  int errors = 0;

  sw_cmd_conditioner #(
    .DEBOUNCE_CYCLES(DC),
    .TICK_DIV       (TD)
  ) dut (
    .CLOCK50(clk),
    .KEY0   (rst_n),
    .SW_IN  (sw),
    .W      (w),
    .W_CHG  (w_chg),
    .TICK   (tick),
    .CMD    (cmd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: edges counted from reset release; W bit flips when the
  // synchronised sample (input two edges earlier) disagreed with W on each of
  // the last DC edges.
  int         k;
  logic [1:0] sw_hist[$];
  logic [1:0] s_hist[$];
  logic [1:0] m_w;
  logic [1:0] m_cmd;
  logic       m_chg;
  logic       m_tick;

  function automatic logic [1:0] ref_cmd(input logic [1:0] lv);
    case (lv)
      2'b10:   return 2'b01;
      2'b01:   return 2'b10;
      2'b11:   return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  task automatic model_reset();
    k = 0;
    sw_hist.delete();
    s_hist.delete();
    m_w = 2'b00;
    m_cmd = 2'b00;
    m_chg = 1'b0;
    m_tick = 1'b0;
  endtask

  task automatic model_edge(input logic [1:0] sw_now);
    logic [1:0] s;
    logic [1:0] nw;
    logic       all_diff;
    k++;
    sw_hist.push_back(sw_now);
    s = (k >= 3) ? sw_hist[k-3] : 2'b00;
    s_hist.push_back(s);
    nw = m_w;
    for (int i = 0; i < 2; i++) begin
      if (k >= DC) begin
        all_diff = 1'b1;
        for (int j = 0; j < DC; j++)
          if (s_hist[k-1-j][i] == m_w[i]) all_diff = 1'b0;
        if (all_diff) nw[i] = ~m_w[i];
      end
    end
    m_tick = ((k % TD) == 0);
    if (m_tick) m_cmd = ref_cmd(m_w);
    m_chg = (nw != m_w);
    m_w = nw;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".W"}, 32'(w), 32'(m_w));
    check({tag, ".W_CHG"}, 32'(w_chg), 32'(m_chg));
    check({tag, ".TICK"}, 32'(tick), 32'(m_tick));
    check({tag, ".CMD"}, 32'(cmd), 32'(m_cmd));
  endtask

  task automatic cycle(input logic [1:0] next_sw);
    @(posedge clk);
    model_edge(sw);
    #1;
    check_all("cyc");
    sw = next_sw;
  endtask

  task automatic hold(input logic [1:0] v, input int n);
    for (int i = 0; i < n; i++) cycle(v);
  endtask

  task automatic async_reset_pulse();
    #2 rst_n = 1'b0;
    #1;
    check("rst.W", 32'(w), 32'd0);
    check("rst.W_CHG", 32'(w_chg), 32'd0);
    check("rst.TICK", 32'(tick), 32'd0);
    check("rst.CMD", 32'(cmd), 32'd0);
    model_reset();
    #1 rst_n = 1'b1;
  endtask

  int chg_seen;
  int w_moved;

  initial begin
    model_reset();
    rst_n = 1'b0;
    sw = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    check("init.W", 32'(w), 32'd0);
    check("init.W_CHG", 32'(w_chg), 32'd0);
    check("init.TICK", 32'(tick), 32'd0);
    check("init.CMD", 32'(cmd), 32'd0);
    rst_n = 1'b1;

    // Free-run: ticks at 8, 16, 24
    hold(2'b00, 26);

    // Clean press forward then release
    hold(2'b10, 20);
    hold(2'b00, 20);

    // Bounce on backward switch: 3-cycle pulses never reach W
    chg_seen = 0;
    w_moved = 0;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 3; i++) begin
        cycle(2'b01);
        chg_seen += int'(w_chg);
        w_moved += int'(w != 2'b00);
      end
      for (int i = 0; i < 3; i++) begin
        cycle(2'b00);
        chg_seen += int'(w_chg);
        w_moved += int'(w != 2'b00);
      end
    end
    for (int i = 0; i < 10; i++) begin
      cycle(2'b00);
      chg_seen += int'(w_chg);
      w_moved += int'(w != 2'b00);
    end
    check("bounce.W_CHG_count", 32'(chg_seen), 32'd0);
    check("bounce.W_moved", 32'(w_moved), 32'd0);
    // 4-cycle stable pulse does propagate
    hold(2'b01, 4);
    hold(2'b00, 16);

    // Fault and dual change
    hold(2'b11, 20);
    hold(2'b01, 20);
    hold(2'b00, 20);

    // Coincident W flip and tick edge
    while ((k % TD) != 2) cycle(2'b00);
    sw = 2'b10;
    hold(2'b10, 6);
    check("coinc.W", 32'(w), 32'h2);
    check("coinc.TICK", 32'(tick), 32'd1);
    check("coinc.CMD", 32'(cmd), 32'h0);
    hold(2'b10, 8);
    check("coinc_next.TICK", 32'(tick), 32'd1);
    check("coinc_next.CMD", 32'(cmd), 32'h1);

    // Reset mid-operation with forward switch held
    async_reset_pulse();
    hold(2'b10, 6);
    check("rst6.W", 32'(w), 32'h2);
    check("rst6.W_CHG", 32'(w_chg), 32'd1);
    hold(2'b10, 2);
    check("rst8.TICK", 32'(tick), 32'd1);
    check("rst8.CMD", 32'(cmd), 32'h1);

    // Random segments, including occasional short bounces
    for (int seg = 0; seg < 60; seg++) begin
      hold(2'($urandom_range(0, 3)), $urandom_range(1, 12));
    end
    async_reset_pulse();
    for (int seg = 0; seg < 30; seg++) begin
      hold(2'($urandom_range(0, 3)), $urandom_range(1, 10));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
